// File: rtl/fetch_sequencer.sv
// PC sequencing control: arbitrates sequential fetch, jump/branch redirects,
// hazard stalls and halt/resume. All outputs are registered.
module fetch_sequencer #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_in,
  input  logic       jump_req,
  input  logic [7:0] jump_target,
  input  logic       br_req,
  input  logic       br_taken,
  input  logic [7:0] br_offset,
  input  logic       halt_req,
  input  logic       resume,
  output logic       pc_en,
  output logic       nia,
  output logic       branch,
  output logic [7:0] imj,
  output logic [7:0] imi,
  output logic       hold_if,
  output logic       flush_id,
  output logic [1:0] state,
  output logic [7:0] redirect_cnt
);

  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2, HALTED = 2'd3} st_t;

  st_t        st_q, st_d;
  logic [3:0] fcnt_q, fcnt_d;
  logic       pc_en_d, nia_d, branch_d, hold_d, flush_d;
  logic [7:0] imj_d, imi_d, cnt_d;
  logic       redirect;

  assign redirect = jump_req | (br_req & br_taken);
  assign state    = st_q;

  always_comb begin
    st_d     = st_q;
    fcnt_d   = fcnt_q;
    pc_en_d  = 1'b0;
    nia_d    = 1'b1;
    branch_d = 1'b0;
    imj_d    = 8'd0;
    imi_d    = 8'd0;
    hold_d   = 1'b0;
    flush_d  = 1'b0;
    cnt_d    = redirect_cnt;
    case (st_q)
      RUN, STALL: begin
        if (halt_req) begin
          st_d   = HALTED;
          hold_d = 1'b1;
        end else if (redirect) begin
          // redirect wins over a pending stall; jump wins over branch
          st_d    = FLUSH;
          fcnt_d  = 4'(FLUSH_CYCLES);
          pc_en_d = 1'b1;
          flush_d = 1'b1;
          cnt_d   = (redirect_cnt == 8'hFF) ? 8'hFF : redirect_cnt + 8'd1;
          if (jump_req) begin
            nia_d = 1'b0;
            imj_d = jump_target;
          end else begin
            branch_d = 1'b1;
            imi_d    = br_offset;
          end
        end else if (stall_in) begin
          st_d   = STALL;
          hold_d = 1'b1;
        end else begin
          st_d    = RUN;
          pc_en_d = 1'b1;
        end
      end
      FLUSH: begin
        if (halt_req) begin
          st_d   = HALTED;
          fcnt_d = 4'd0;
          hold_d = 1'b1;
        end else if (fcnt_q <= 4'd1) begin
          st_d    = RUN;
          fcnt_d  = 4'd0;
          pc_en_d = 1'b1;
        end else begin
          fcnt_d  = fcnt_q - 4'd1;
          pc_en_d = 1'b1;
          flush_d = 1'b1;
        end
      end
      HALTED: begin
        if (resume && !halt_req) begin
          st_d    = RUN;
          pc_en_d = 1'b1;
        end else begin
          hold_d = 1'b1;
        end
      end
      default: st_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q         <= RUN;
      fcnt_q       <= 4'd0;
      pc_en        <= 1'b0;
      nia          <= 1'b1;
      branch       <= 1'b0;
      imj          <= 8'd0;
      imi          <= 8'd0;
      hold_if      <= 1'b0;
      flush_id     <= 1'b0;
      redirect_cnt <= 8'd0;
    end else begin
      st_q         <= st_d;
      fcnt_q       <= fcnt_d;
      pc_en        <= pc_en_d;
      nia          <= nia_d;
      branch       <= branch_d;
      imj          <= imj_d;
      imi          <= imi_d;
      hold_if      <= hold_d;
      flush_id     <= flush_d;
      redirect_cnt <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; a second instance with FLUSH_CYCLES=1
// covers the minimum flush length.
module tb_fetch_sequencer;
  logic       clk = 1'b0;
  logic       rst, stall_in, jump_req, br_req, br_taken, halt_req, resume;
  logic [7:0] jump_target, br_offset;
  logic       pc_en, nia, branch, hold_if, flush_id;
  logic [7:0] imj, imi, redirect_cnt;
  logic [1:0] state;
  logic       pc_en1, nia1, branch1, hold_if1, flush_id1;
  logic [7:0] imj1, imi1, redirect_cnt1;
  logic [1:0] state1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .jump_req(jump_req),
    .jump_target(jump_target), .br_req(br_req), .br_taken(br_taken),
    .br_offset(br_offset), .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .nia(nia), .branch(branch), .imj(imj), .imi(imi),
    .hold_if(hold_if), .flush_id(flush_id), .state(state),
    .redirect_cnt(redirect_cnt)
  );

  fetch_sequencer #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .stall_in(stall_in), .jump_req(jump_req),
    .jump_target(jump_target), .br_req(br_req), .br_taken(br_taken),
    .br_offset(br_offset), .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en1), .nia(nia1), .branch(branch1), .imj(imj1), .imi(imi1),
    .hold_if(hold_if1), .flush_id(flush_id1), .state(state1),
    .redirect_cnt(redirect_cnt1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_in = 0; jump_req = 0; br_req = 0; br_taken = 0;
    halt_req = 0; resume = 0; jump_target = 8'h00; br_offset = 8'h00;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".state"}, {6'd0, state}, 8'd0);
    chk({tag, ".pc_en"}, {7'd0, pc_en}, 8'd0);
    chk({tag, ".nia"}, {7'd0, nia}, 8'd1);
    chk({tag, ".branch"}, {7'd0, branch}, 8'd0);
    chk({tag, ".imj"}, imj, 8'd0);
    chk({tag, ".imi"}, imi, 8'd0);
    chk({tag, ".hold"}, {7'd0, hold_if}, 8'd0);
    chk({tag, ".flush"}, {7'd0, flush_id}, 8'd0);
    chk({tag, ".cnt"}, redirect_cnt, 8'd0);
  endtask

  initial begin
    idle();
    rst = 0;
    step(); step();
    chk_reset("rst");

    // leave reset, idle fetch
    rst = 1;
    step();
    chk("run.pc_en", {7'd0, pc_en}, 8'd1);
    chk("run.nia", {7'd0, nia}, 8'd1);
    chk("run.state", {6'd0, state}, 8'd0);
    step();
    chk("run2.pc_en", {7'd0, pc_en}, 8'd1);

    // jump to 0x40
    jump_req = 1; jump_target = 8'h40;
    step();
    idle();
    chk("jmp.nia", {7'd0, nia}, 8'd0);
    chk("jmp.imj", imj, 8'h40);
    chk("jmp.flush", {7'd0, flush_id}, 8'd1);
    chk("jmp.pc_en", {7'd0, pc_en}, 8'd1);
    chk("jmp.cnt", redirect_cnt, 8'd1);
    chk("jmp.state", {6'd0, state}, 8'd2);
    chk("jmp.state1", {6'd0, state1}, 8'd2);
    step();
    chk("fl1.state", {6'd0, state}, 8'd2);
    chk("fl1.imj", imj, 8'd0);
    chk("fl1.nia", {7'd0, nia}, 8'd1);
    chk("fl1.flush", {7'd0, flush_id}, 8'd1);
    chk("fc1.state1", {6'd0, state1}, 8'd0);
    chk("fc1.flush1", {7'd0, flush_id1}, 8'd0);
    step();
    chk("fl2.state", {6'd0, state}, 8'd0);
    chk("fl2.flush", {7'd0, flush_id}, 8'd0);
    chk("fl2.pc_en", {7'd0, pc_en}, 8'd1);

    // stall, then taken branch while stalled
    stall_in = 1;
    step();
    chk("stl.state", {6'd0, state}, 8'd1);
    chk("stl.pc_en", {7'd0, pc_en}, 8'd0);
    chk("stl.hold", {7'd0, hold_if}, 8'd1);
    br_req = 1; br_taken = 1; br_offset = 8'hFC;
    step();
    br_req = 0; br_taken = 0; br_offset = 8'h00;
    chk("bst.branch", {7'd0, branch}, 8'd1);
    chk("bst.imi", imi, 8'hFC);
    chk("bst.pc_en", {7'd0, pc_en}, 8'd1);
    chk("bst.hold", {7'd0, hold_if}, 8'd0);
    chk("bst.state", {6'd0, state}, 8'd2);
    chk("bst.cnt", redirect_cnt, 8'd2);
    step();
    chk("bfl.state", {6'd0, state}, 8'd2);
    chk("bfl.pc_en", {7'd0, pc_en}, 8'd1);
    step();
    chk("bfl.exit", {6'd0, state}, 8'd0);
    step();
    chk("bfl.restall", {6'd0, state}, 8'd1);
    stall_in = 0; br_req = 1; br_taken = 0; br_offset = 8'h22;
    step();
    idle();
    chk("nt.state", {6'd0, state}, 8'd0);
    chk("nt.cnt", redirect_cnt, 8'd2);
    chk("nt.branch", {7'd0, branch}, 8'd0);
    chk("nt.imi", imi, 8'd0);

    // jump and taken branch together: jump wins
    jump_req = 1; jump_target = 8'h10; br_req = 1; br_taken = 1; br_offset = 8'h05;
    step();
    idle();
    chk("jb.nia", {7'd0, nia}, 8'd0);
    chk("jb.imj", imj, 8'h10);
    chk("jb.branch", {7'd0, branch}, 8'd0);
    chk("jb.imi", imi, 8'd0);
    chk("jb.cnt", redirect_cnt, 8'd3);
    jump_req = 1; jump_target = 8'h55;
    step();
    idle();
    chk("wp.state", {6'd0, state}, 8'd2);
    chk("wp.nia", {7'd0, nia}, 8'd1);
    chk("wp.imj", imj, 8'd0);
    chk("wp.cnt", redirect_cnt, 8'd3);

    // halt mid-flush, resume blocked while halt held, then resume
    halt_req = 1;
    step();
    chk("hlt.state", {6'd0, state}, 8'd3);
    chk("hlt.pc_en", {7'd0, pc_en}, 8'd0);
    chk("hlt.hold", {7'd0, hold_if}, 8'd1);
    chk("hlt.flush", {7'd0, flush_id}, 8'd0);
    resume = 1; jump_req = 1; jump_target = 8'h77;
    step();
    chk("hr.state", {6'd0, state}, 8'd3);
    chk("hr.cnt", redirect_cnt, 8'd3);
    chk("hr.imj", imj, 8'd0);
    idle();
    resume = 1;
    step();
    idle();
    chk("res.state", {6'd0, state}, 8'd0);
    chk("res.pc_en", {7'd0, pc_en}, 8'd1);
    chk("res.hold", {7'd0, hold_if}, 8'd0);

    // counter saturation: 3 + 260 redirects clamps at 255
    for (int i = 0; i < 260; i++) begin
      jump_req = 1; jump_target = 8'(i);
      step();
      jump_req = 0;
      step(); step();
    end
    chk("sat.cnt", redirect_cnt, 8'hFF);
    jump_req = 1; jump_target = 8'h99;
    step();
    idle();
    chk("sat2.cnt", redirect_cnt, 8'hFF);
    chk("sat2.state", {6'd0, state}, 8'd2);
    chk("sat2.imj", imj, 8'h99);

    // reset mid-flush, with a request pending
    rst = 0; jump_req = 1; jump_target = 8'h33;
    step();
    chk_reset("rstfl");
    idle();
    rst = 1;
    step();
    chk("post.pc_en", {7'd0, pc_en}, 8'd1);
    chk("post.state", {6'd0, state}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck want finish");
    $fatal(1);
  end
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control block that sequences the 8-bit program counter of the pipelined processor. It arbitrates between sequential fetch, jump redirects, taken-branch redirects, hazard stalls and halt/resume. It drives the PC's next-address controls: `pc_en`, `nia`, `branch`, `imj` and `imi`. It also drives the IF/ID hold and flush signals and keeps a saturating redirect counter.

## Interface
Parameters:
- FLUSH_CYCLES, default 2: cycles spent in FLUSH after an accepted redirect; legal range 1–15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- stall_in  input  1  hazard unit requests the PC and IF/ID hold.
- jump_req  input  1  EX stage resolves a jump.
- jump_target  input  8  absolute jump address.
- br_req  input  1  EX stage resolves a conditional branch.
- br_taken  input  1  branch outcome; valid when br_req=1.
- br_offset  input  8  branch displacement, two's complement.
- halt_req  input  1  stop fetching.
- resume  input  1  restart fetching from HALTED.
- pc_en  output  1  PC may update this cycle.
- nia  output  1  1 = sequential/branch path, 0 = load imj.
- branch  output  1  1 = PC takes pc+imi+1.
- imj  output  8  jump target to PC.
- imi  output  8  branch offset to PC.
- hold_if  output  1  IF/ID register holds its contents.
- flush_id  output  1  IF/ID contents replaced by a bubble.
- state  output  2  RUN=0, STALL=1, FLUSH=2, HALTED=3.
- redirect_cnt  output  8  number of accepted redirects, saturating.

## Operation
- FSM with four states: RUN, STALL, FLUSH, HALTED. A 4-bit flush counter `fcnt` is internal.
- A redirect is either `jump_req=1` or `br_req=1 && br_taken=1`.
- Request priority, evaluated each edge, highest first:
  - halt_req
  - jump_req
  - taken branch
  - stall_in
  - sequential
- br_req with br_taken=0 is not a redirect; it is treated as sequential.
- RUN:
  - halt_req → HALTED.
  - Redirect → FLUSH, with fcnt=FLUSH_CYCLES.
  - stall_in → STALL.
  - Otherwise stay in RUN, with pc_en=1, nia=1, branch=0.
- Redirect cycle outputs (the registered outputs following acceptance):
  - pc_en=1 and flush_id=1.
  - Jump: nia=0, imj=jump_target, branch=0.
  - Taken branch: nia=1, branch=1, imi=br_offset.
  - redirect_cnt increments and saturates at 255.
- STALL:
  - Outputs: pc_en=0, hold_if=1.
  - stall_in=0 → RUN.
  - Redirect overrides the stall: → FLUSH; hold_if=0 in the redirect cycle.
  - halt_req → HALTED.
- FLUSH:
  - Entered with fcnt=FLUSH_CYCLES.
  - Each cycle: pc_en=1, nia=1, branch=0, flush_id=1, fcnt decrements.
  - fcnt reaching 1 → RUN on the next edge.
  - jump_req and br_req are ignored (wrong-path) and not counted.
  - stall_in is ignored.
  - halt_req → HALTED and clears fcnt.
- HALTED:
  - Outputs: pc_en=0, hold_if=1, flush_id=0.
  - resume=1 and halt_req=0 → RUN.
  - halt_req=1 with resume=1 → stay in HALTED.
  - Redirect requests are ignored.
- Outside a redirect cycle, imj=0 and imi=0.

## Timing
- All outputs are registered. Inputs sampled at edge N produce outputs after edge N. The PC consumes them at edge N+1, giving 1 cycle of control latency.
- Reset (rst=0 at an edge), output values:
  - state=RUN, fcnt=0.
  - pc_en=0, nia=1, branch=0.
  - imj=0, imi=0.
  - hold_if=0, flush_id=0.
  - redirect_cnt=0.
- Reset takes effect in any state, including mid-FLUSH and HALTED, and discards any pending request.
- First edge with rst=1 and no requests: pc_en=1.
- A redirect presented while stall_in=1 is accepted in the same edge; it is never delayed by the stall.
- jump_req and a taken branch in the same cycle: the jump wins; the branch is dropped and counted zero times.
- redirect_cnt at 255 stays at 255 on further redirects.
- FLUSH_CYCLES=1: one flush cycle, then RUN.

## Test plan
- Reset then idle: rst=0 for 2 cycles, then rst=1 → pc_en=0 during reset; pc_en=1, nia=1, state=0 from the first active edge; PC steps 0,1,2,…
- Jump: jump_req=1, jump_target=8'h40 for 1 cycle → next cycle nia=0, imj=8'h40, flush_id=1, redirect_cnt=1; state=2 for 2 cycles, then 0.
- Branch vs stall: stall_in=1 held; br_req=1, br_taken=1, br_offset=8'hFC at the same edge → branch=1, imi=8'hFC, pc_en=1, hold_if=0, state=2. Then br_req=1, br_taken=0 → no redirect, redirect_cnt unchanged.
- Simultaneous requests: jump_req=1 (target 8'h10) and taken branch in one cycle → nia=0, imj=8'h10, branch=0, redirect_cnt increments by 1. A jump_req during FLUSH is ignored.
- Halt/resume: halt_req mid-FLUSH → state=3, pc_en=0, hold_if=1. resume=1 with halt_req=1 → stays in state 3. resume=1 alone → state=0, pc_en=1.
- Saturation and reset: 260 jumps separated by flushes → redirect_cnt=255. rst=0 mid-FLUSH → all outputs return to their reset values on that edge.
